mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares one downstream memory port between the I-cache refill path (read bursts)
//   and the LSU data path (single-beat reads/writes). Latches one-cycle request pulses,
//   arbitrates, issues one registered request downstream and routes response beats
//   back to the owner. Sits between ICache/LSU and the AXI4 master bridge.
// PARAMETERS
//   D_PRIORITY  1   1: D side wins when both pending; 0: round-robin (alternate last grant)
//   ADDR_W      32  address width
// PORTS
//   clk       in   1   clock
//   rst       in   1   reset, asynchronous, active-high
//   i_req     in   1   I refill request pulse (1 cycle)
//   i_addr    in   32  line-aligned burst address (sampled with i_req)
//   i_len     in   8   burst length-1 (sampled with i_req)
//   i_flush   in   1   cancel I request (pending or in flight)
//   i_rvalid  out  1   I beat valid
//   i_rdata   out  32  I beat data
//   i_rlast   out  1   I last beat
//   d_req     in   1   D request pulse (1 cycle)
//   d_wen     in   1   1 = write, 0 = read
//   d_addr    in   32  D address
//   d_wdata   in   32  write data
//   d_wstrb   in   4   byte strobes
//   d_done    out  1   D complete (read data valid or write ack), 1-cycle pulse
//   d_rdata   out  32  D read data (valid with d_done on reads)
//   m_req     out  1   downstream request pulse (1 cycle)
//   m_wen     out  1   downstream write
//   m_addr    out  32  downstream address
//   m_len     out  8   burst length-1 (0 for D)
//   m_wdata   out  32  downstream write data
//   m_wstrb   out  4   downstream strobes
//   m_rvalid  in   1   read beat valid
//   m_rdata   in   32  read beat data
//   m_rlast   in   1   last read beat
//   m_bvalid  in   1   write response
// BEHAVIOUR
// - Reset: all outputs 0; state IDLE; pending flags clear; last_grant = I.
// - Pending regs: i_pend/d_pend set on req pulse with addr/len/data captured. A second
//   pulse on a side already pending or owning the port is ignored (first request kept).
// - FSM: IDLE -> ISSUE_I | ISSUE_D when any pending; ISSUE_x drives m_req=1 plus fields
//   for exactly one cycle, clears x_pend, -> WAIT_I | WAIT_D.
//   WAIT_I -> IDLE on m_rvalid&&m_rlast; WAIT_D -> IDLE on m_rvalid (read) or m_bvalid (write).
// - Arbitration (IDLE only): single pending side wins; both pending: D_PRIORITY=1 -> D,
//   else side != last_grant. last_grant updated on entering ISSUE_x.
// - Latency: req pulse at cycle N with port idle -> m_req at N+2 (latch N, ISSUE N+1
//   registered output visible N+2 edge-aligned: m_req high during cycle N+2).
// - Responses combinational: i_rvalid = m_rvalid & WAIT_I & !drop; i_rdata/i_rlast
//   pass-through. d_done = WAIT_D & (d_wen_r ? m_bvalid : m_rvalid); d_rdata = m_rdata.
//   Beats outside WAIT states are ignored.
// - Flush: i_flush clears i_pend (no issue). In ISSUE_I/WAIT_I sets drop: burst is still
//   drained to m_rlast (port not released early) but i_rvalid suppressed; drop clears
//   on leaving WAIT_I. Flush never affects D side. i_req same cycle as i_flush ignored.
// - Simultaneous: req pulse in cycle of completion is latched; arbitrated next IDLE cycle.
//   IDLE is always one cycle (no back-to-back issue in completion cycle).
// - Reset mid-transfer: immediate return to IDLE, pending/drop lost; downstream bridge
//   shares the same reset.
// TESTING
// - I only: i_req addr=0x3000_0010 len=3, 4 beats -> m_req 1 cycle, m_len=3, 4 i_rvalid,
//   i_rlast on 4th, d_done never.
// - Conflict: i_req and d_req same cycle, D_PRIORITY=1 -> D (read 0x8000_0000) issued
//   first, d_done with data; I burst issued on following IDLE+1.
// - Round-robin D_PRIORITY=0: both pending twice in a row -> grants alternate D,I / I,D
//   per last_grant.
// - Flush in WAIT_I after beat 1 of 4 -> i_rvalid low for beats 2-4, port busy until
//   m_rlast, pending d_req issued after.
// - Write: d_req wen=1 wstrb=0x3 data=0xDEAD_BEEF -> m_wen=1, fields match; d_done
//   only on m_bvalid, not on stray m_rvalid.
// - Reset asserted in WAIT_D -> outputs 0 same cycle, IDLE, later m_bvalid ignored.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ---- mem_port_arbiter: shares one memory port between I-cache burst refills and LSU single beats ----
// ---- Revision: 1.0 ------------------------------------------------------------------------------------

module mem_port_arbiter #(
  parameter bit D_PRIORITY = 1'b1,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [7:0]        i_len,
  input  logic              i_flush,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  output logic              i_rlast,
  input  logic              d_req,
  input  logic              d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_wstrb,
  output logic              d_done,
  output logic [31:0]       d_rdata,
  output logic              m_req,
  output logic              m_wen,
  output logic [ADDR_W-1:0] m_addr,
  output logic [7:0]        m_len,
  output logic [31:0]       m_wdata,
  output logic [3:0]        m_wstrb,
  input  logic              m_rvalid,
  input  logic [31:0]       m_rdata,
  input  logic              m_rlast,
  input  logic              m_bvalid
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE_I = 3'd1,
    S_ISSUE_D = 3'd2,
    S_WAIT_I  = 3'd3,
    S_WAIT_D  = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic                i_pend_q, i_pend_d;
  logic                d_pend_q, d_pend_d;
  logic                drop_q, drop_d;
  logic                last_d_q, last_d_d;
  logic [ADDR_W-1:0]   i_addr_q, i_addr_d;
  logic [7:0]          i_len_q, i_len_d;
  logic                d_wen_q, d_wen_d;
  logic [ADDR_W-1:0]   d_addr_q, d_addr_d;
  logic [31:0]         d_wdata_q, d_wdata_d;
  logic [3:0]          d_wstrb_q, d_wstrb_d;
  logic                m_req_q, m_req_d;
  logic                m_wen_q, m_wen_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [7:0]          m_len_q, m_len_d;
  logic [31:0]         m_wdata_q, m_wdata_d;
  logic [3:0]          m_wstrb_q, m_wstrb_d;

  logic w_i_done, w_d_done, w_i_own, w_d_own, w_i_pend, w_grant_d;

  // m_wen_q holds the in-flight D direction until the transfer completes
  assign w_i_done = (state_q == S_WAIT_I) && m_rvalid && m_rlast;
  assign w_d_done = (state_q == S_WAIT_D) && (m_wen_q ? m_bvalid : m_rvalid);
  // A side stops owning the port in its completion cycle, so a new pulse there is kept
  assign w_i_own  = (state_q == S_ISSUE_I) || ((state_q == S_WAIT_I) && !w_i_done);
  assign w_d_own  = (state_q == S_ISSUE_D) || ((state_q == S_WAIT_D) && !w_d_done);
  assign w_i_pend = i_pend_q && !i_flush;

  always_comb begin
    w_grant_d = 1'b0;
    if (d_pend_q && !w_i_pend)      w_grant_d = 1'b1;
    else if (d_pend_q && w_i_pend)  w_grant_d = D_PRIORITY ? 1'b1 : !last_d_q;
  end

  always_comb begin
    state_d   = state_q;
    i_pend_d  = i_pend_q;
    d_pend_d  = d_pend_q;
    drop_d    = drop_q;
    last_d_d  = last_d_q;
    i_addr_d  = i_addr_q;
    i_len_d   = i_len_q;
    d_wen_d   = d_wen_q;
    d_addr_d  = d_addr_q;
    d_wdata_d = d_wdata_q;
    d_wstrb_d = d_wstrb_q;
    m_req_d   = 1'b0;
    m_wen_d   = m_wen_q;
    m_addr_d  = m_addr_q;
    m_len_d   = m_len_q;
    m_wdata_d = m_wdata_q;
    m_wstrb_d = m_wstrb_q;

    if (i_flush) begin
      i_pend_d = 1'b0;
    end else if (i_req && !i_pend_q && !w_i_own) begin
      i_pend_d = 1'b1;
      i_addr_d = i_addr;
      i_len_d  = i_len;
    end
    if (d_req && !d_pend_q && !w_d_own) begin
      d_pend_d  = 1'b1;
      d_wen_d   = d_wen;
      d_addr_d  = d_addr;
      d_wdata_d = d_wdata;
      d_wstrb_d = d_wstrb;
    end

    unique case (state_q)
      S_IDLE: begin
        if (w_grant_d) begin
          state_d   = S_ISSUE_D;
          d_pend_d  = 1'b0;
          last_d_d  = 1'b1;
          m_req_d   = 1'b1;
          m_wen_d   = d_wen_q;
          m_addr_d  = d_addr_q;
          m_len_d   = 8'd0;
          m_wdata_d = d_wdata_q;
          m_wstrb_d = d_wstrb_q;
        end else if (w_i_pend) begin
          state_d   = S_ISSUE_I;
          i_pend_d  = 1'b0;
          last_d_d  = 1'b0;
          m_req_d   = 1'b1;
          m_wen_d   = 1'b0;
          m_addr_d  = i_addr_q;
          m_len_d   = i_len_q;
          m_wdata_d = 32'd0;
          m_wstrb_d = 4'd0;
        end
      end
      S_ISSUE_I: begin
        state_d = S_WAIT_I;
        if (i_flush) drop_d = 1'b1;
      end
      S_ISSUE_D: state_d = S_WAIT_D;
      S_WAIT_I: begin
        if (i_flush) drop_d = 1'b1;
        if (w_i_done) begin
          state_d = S_IDLE;
          drop_d  = 1'b0;
        end
      end
      S_WAIT_D: if (w_d_done) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      i_pend_q  <= 1'b0;
      d_pend_q  <= 1'b0;
      drop_q    <= 1'b0;
      last_d_q  <= 1'b0;
      i_addr_q  <= '0;
      i_len_q   <= '0;
      d_wen_q   <= 1'b0;
      d_addr_q  <= '0;
      d_wdata_q <= '0;
      d_wstrb_q <= '0;
      m_req_q   <= 1'b0;
      m_wen_q   <= 1'b0;
      m_addr_q  <= '0;
      m_len_q   <= '0;
      m_wdata_q <= '0;
      m_wstrb_q <= '0;
    end else begin
      state_q   <= state_d;
      i_pend_q  <= i_pend_d;
      d_pend_q  <= d_pend_d;
      drop_q    <= drop_d;
      last_d_q  <= last_d_d;
      i_addr_q  <= i_addr_d;
      i_len_q   <= i_len_d;
      d_wen_q   <= d_wen_d;
      d_addr_q  <= d_addr_d;
      d_wdata_q <= d_wdata_d;
      d_wstrb_q <= d_wstrb_d;
      m_req_q   <= m_req_d;
      m_wen_q   <= m_wen_d;
      m_addr_q  <= m_addr_d;
      m_len_q   <= m_len_d;
      m_wdata_q <= m_wdata_d;
      m_wstrb_q <= m_wstrb_d;
    end
  end

  assign i_rvalid = m_rvalid && (state_q == S_WAIT_I) && !drop_q && !i_flush;
  assign i_rdata  = m_rdata;
  assign i_rlast  = m_rlast;
  assign d_done   = w_d_done;
  assign d_rdata  = m_rdata;
  assign m_req    = m_req_q;
  assign m_wen    = m_wen_q;
  assign m_addr   = m_addr_q;
  assign m_len    = m_len_q;
  assign m_wdata  = m_wdata_q;
  assign m_wstrb  = m_wstrb_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ---- tb_mem_port_arbiter: directed checks, instance 0 with D priority, instance 1 round-robin ----
// ---- Revision: 1.0 ----------------------------------------------------------------------------------

module tb_mem_port_arbiter;

  logic clk;
  logic rst;

  logic        i_req    [2];
  logic [31:0] i_addr   [2];
  logic [7:0]  i_len    [2];
  logic        i_flush  [2];
  logic        i_rvalid [2];
  logic [31:0] i_rdata  [2];
  logic        i_rlast  [2];
  logic        d_req    [2];
  logic        d_wen    [2];
  logic [31:0] d_addr   [2];
  logic [31:0] d_wdata  [2];
  logic [3:0]  d_wstrb  [2];
  logic        d_done   [2];
  logic [31:0] d_rdata  [2];
  logic        m_req    [2];
  logic        m_wen    [2];
  logic [31:0] m_addr   [2];
  logic [7:0]  m_len    [2];
  logic [31:0] m_wdata  [2];
  logic [3:0]  m_wstrb  [2];
  logic        m_rvalid [2];
  logic [31:0] m_rdata  [2];
  logic        m_rlast  [2];
  logic        m_bvalid [2];

  int total = 0;
  int bad   = 0;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    mem_port_arbiter #(.D_PRIORITY(k == 0), .ADDR_W(32)) u_dut (
      .clk(clk), .rst(rst),
      .i_req(i_req[k]), .i_addr(i_addr[k]), .i_len(i_len[k]), .i_flush(i_flush[k]),
      .i_rvalid(i_rvalid[k]), .i_rdata(i_rdata[k]), .i_rlast(i_rlast[k]),
      .d_req(d_req[k]), .d_wen(d_wen[k]), .d_addr(d_addr[k]), .d_wdata(d_wdata[k]),
      .d_wstrb(d_wstrb[k]), .d_done(d_done[k]), .d_rdata(d_rdata[k]),
      .m_req(m_req[k]), .m_wen(m_wen[k]), .m_addr(m_addr[k]), .m_len(m_len[k]),
      .m_wdata(m_wdata[k]), .m_wstrb(m_wstrb[k]),
      .m_rvalid(m_rvalid[k]), .m_rdata(m_rdata[k]), .m_rlast(m_rlast[k]),
      .m_bvalid(m_bvalid[k])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic beat(input int k, input logic [31:0] data, input logic last);
    m_rvalid[k] = 1'b1;
    m_rdata[k]  = data;
    m_rlast[k]  = last;
    #1;
  endtask

  task automatic quiet(input int k);
    i_req[k] = 1'b0; d_req[k] = 1'b0; i_flush[k] = 1'b0;
    m_rvalid[k] = 1'b0; m_rlast[k] = 1'b0; m_bvalid[k] = 1'b0; m_rdata[k] = 32'd0;
  endtask

  task automatic post_i(input int k, input logic [31:0] a, input logic [7:0] l);
    i_req[k] = 1'b1; i_addr[k] = a; i_len[k] = l;
  endtask

  task automatic post_d(input int k, input logic w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] ws);
    d_req[k] = 1'b1; d_wen[k] = w; d_addr[k] = a; d_wdata[k] = wd; d_wstrb[k] = ws;
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      quiet(k);
      i_addr[k] = '0; i_len[k] = '0; d_wen[k] = 1'b0;
      d_addr[k] = '0; d_wdata[k] = '0; d_wstrb[k] = '0;
    end
    step(); step();
    chk("rst_m_req",   32'(m_req[0]),    32'd0);
    chk("rst_m_addr",  m_addr[0],        32'd0);
    chk("rst_i_rvalid",32'(i_rvalid[0]), 32'd0);
    chk("rst_d_done",  32'(d_done[0]),   32'd0);
    rst = 1'b0;
    step();

    // I-only 4-beat burst
    post_i(0, 32'h3000_0010, 8'd3);
    step(); i_req[0] = 1'b0;
    chk("i_latch_no_req", 32'(m_req[0]), 32'd0);
    step();
    chk("i_m_req",  32'(m_req[0]), 32'd1);
    chk("i_m_addr", m_addr[0],     32'h3000_0010);
    chk("i_m_len",  32'(m_len[0]), 32'd3);
    chk("i_m_wen",  32'(m_wen[0]), 32'd0);
    step();
    chk("i_m_req_1cyc", 32'(m_req[0]), 32'd0);
    for (int b = 0; b < 4; b++) begin
      beat(0, 32'hA000 + 32'(b), b == 3);
      chk("i_rvalid", 32'(i_rvalid[0]), 32'd1);
      chk("i_rdata",  i_rdata[0],       32'hA000 + 32'(b));
      chk("i_rlast",  32'(i_rlast[0]),  32'(b == 3));
      chk("i_no_dd",  32'(d_done[0]),   32'd0);
      step();
    end
    quiet(0);

    // Conflict under D priority: D first, I on the IDLE cycle after
    post_i(0, 32'h3000_0040, 8'd1);
    post_d(0, 1'b0, 32'h8000_0000, 32'd0, 4'd0);
    step(); quiet(0);
    step();
    chk("cf_m_req_d",  32'(m_req[0]), 32'd1);
    chk("cf_m_addr_d", m_addr[0],     32'h8000_0000);
    chk("cf_m_len_d",  32'(m_len[0]), 32'd0);
    step();
    beat(0, 32'h1234_5678, 1'b1);
    chk("cf_d_done",  32'(d_done[0]),   32'd1);
    chk("cf_d_rdata", d_rdata[0],       32'h1234_5678);
    chk("cf_no_iv",   32'(i_rvalid[0]), 32'd0);
    step(); quiet(0); #1;
    chk("cf_idle_gap", 32'(m_req[0]), 32'd0);
    step();
    chk("cf_m_req_i",  32'(m_req[0]), 32'd1);
    chk("cf_m_addr_i", m_addr[0],     32'h3000_0040);
    chk("cf_m_len_i",  32'(m_len[0]), 32'd1);
    step();
    beat(0, 32'hB0, 1'b0); chk("cf_i_b0", 32'(i_rvalid[0]), 32'd1); step();
    beat(0, 32'hB1, 1'b1); chk("cf_i_b1", 32'(i_rvalid[0]), 32'd1); step();
    quiet(0);

    // Flush after beat 1 of 4, with a D read arriving meanwhile
    post_i(0, 32'h3000_0080, 8'd3);
    step(); quiet(0);
    step(); step();
    beat(0, 32'hC0, 1'b0); chk("fl_b1_valid", 32'(i_rvalid[0]), 32'd1); step();
    quiet(0);
    i_flush[0] = 1'b1;
    post_d(0, 1'b0, 32'h8000_0100, 32'd0, 4'd0);
    step(); quiet(0);
    for (int b = 1; b < 4; b++) begin
      beat(0, 32'hC0 + 32'(b), b == 3);
      chk("fl_dropped", 32'(i_rvalid[0]), 32'd0);
      chk("fl_busy",    32'(m_req[0]),    32'd0);
      step();
    end
    quiet(0); #1;
    chk("fl_idle", 32'(m_req[0]), 32'd0);
    step();
    chk("fl_d_req",  32'(m_req[0]), 32'd1);
    chk("fl_d_addr", m_addr[0],     32'h8000_0100);
    step();
    beat(0, 32'h5555_AAAA, 1'b1);
    chk("fl_d_done", 32'(d_done[0]), 32'd1);
    step(); quiet(0);

    // Write: fields, stray rvalid ignored, done on bvalid
    post_d(0, 1'b1, 32'h8000_0200, 32'hDEAD_BEEF, 4'h3);
    step(); quiet(0);
    step();
    chk("wr_m_req",   32'(m_req[0]),   32'd1);
    chk("wr_m_wen",   32'(m_wen[0]),   32'd1);
    chk("wr_m_addr",  m_addr[0],       32'h8000_0200);
    chk("wr_m_wdata", m_wdata[0],      32'hDEAD_BEEF);
    chk("wr_m_wstrb", 32'(m_wstrb[0]), 32'h3);
    step();
    beat(0, 32'h0, 1'b1);
    chk("wr_stray_rv", 32'(d_done[0]), 32'd0);
    step(); quiet(0);
    m_bvalid[0] = 1'b1; #1;
    chk("wr_bvalid_done", 32'(d_done[0]), 32'd1);
    step(); quiet(0);

    // Reset in WAIT_D with an I request pending
    post_d(0, 1'b0, 32'h8000_0300, 32'd0, 4'd0);
    step(); quiet(0);
    step(); step();
    post_i(0, 32'h3000_0300, 8'd0);
    step(); quiet(0);
    m_rvalid[0] = 1'b1; #1;
    chk("rs_pre_done", 32'(d_done[0]), 32'd1);
    rst = 1'b1; #1;
    chk("rs_d_done", 32'(d_done[0]), 32'd0);
    chk("rs_m_addr", m_addr[0],      32'd0);
    chk("rs_m_req",  32'(m_req[0]),  32'd0);
    quiet(0);
    step(); rst = 1'b0;
    m_bvalid[0] = 1'b1; #1;
    chk("rs_bvalid_ign", 32'(d_done[0]), 32'd0);
    step(); quiet(0);
    for (int c = 0; c < 3; c++) begin
      chk("rs_pend_lost", 32'(m_req[0]), 32'd0);
      step();
    end

    // Round-robin instance: both -> D,I; then D alone; then both -> I,D
    post_i(1, 32'h3000_0100, 8'd0);
    post_d(1, 1'b0, 32'h8000_0400, 32'd0, 4'd0);
    step(); quiet(1);
    step();
    chk("rr1_first_d", m_addr[1], 32'h8000_0400);
    step(); beat(1, 32'h11, 1'b1);
    chk("rr1_d_done", 32'(d_done[1]), 32'd1);
    step(); quiet(1);
    step();
    chk("rr1_second_i", m_addr[1], 32'h3000_0100);
    chk("rr1_i_req",    32'(m_req[1]), 32'd1);
    step(); beat(1, 32'h22, 1'b1);
    chk("rr1_i_beat", 32'(i_rvalid[1]), 32'd1);
    step(); quiet(1);
    post_d(1, 1'b0, 32'h8000_0500, 32'd0, 4'd0);
    step(); quiet(1);
    step();
    chk("rr_d_only", m_addr[1], 32'h8000_0500);
    step(); beat(1, 32'h33, 1'b1); step(); quiet(1);
    post_i(1, 32'h3000_0200, 8'd0);
    post_d(1, 1'b0, 32'h8000_0600, 32'd0, 4'd0);
    step(); quiet(1);
    step();
    chk("rr2_first_i", m_addr[1], 32'h3000_0200);
    step(); beat(1, 32'h44, 1'b1);
    chk("rr2_i_beat", 32'(i_rvalid[1]), 32'd1);
    step(); quiet(1);
    step();
    chk("rr2_second_d", m_addr[1], 32'h8000_0600);
    step(); beat(1, 32'h55, 1'b1);
    chk("rr2_d_done", 32'(d_done[1]), 32'd1);
    step(); quiet(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
